control_unit: RTL and testbench
===============================

# control_unit

Hardwired Moore controller that sequences the single-bus datapath through fetch, decode and execute for a Mini SRC instruction subset. It drives register-select encoder controls (Gra, Grb, Grc, Rin, Rout, BAout), bus-driver and register-load strobes, the ALU operation, and memory Read/Write. It sits between the IR and the datapath, which contains the select/encode logic, the register file, Y, Z, PC, MAR and MDR.

## Interface
Parameters:
- none; widths and encodings are fixed in the shared package.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IR  in  32  current instruction. Opcode is IR[31:27].
- CON  in  1  branch-condition flag from the CON flip-flop.
- mem_ready  in  1  memory completion for the current Read or Write.
- PCout, Zlowout, MDRout, Cout  out  1 each  bus driver enables.
- MARin, PCin, MDRin, IRin, Yin, Zin, CONin  out  1 each  register load enables.
- IncPC  out  1  ALU computes PC+1.
- Read, Write  out  1 each  memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  controls for the select/encode logic.
- alu_op  out  4  ALU operation: ADD=0, SUB=1, AND=2, OR=3. Value 0 when idle.
- run  out  1  high unless halted.

## Operation
- State register with states S_RST, T0–T7 and S_HALT. All outputs are combinational from the state, the opcode and CON.
- S_RST: all outputs 0 and run=1. The first edge after rst_n deasserts moves to T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute, selected by the opcode in T3 onward:
  - add/sub/and/or (00011/00100/01001/01010):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, alu_op, Zin.
    - T5: Zlowout, Gra, Rin.
  - addi/andi/ori (01011/01100/01101): as the R-type sequence, except T4 drives Cout instead of Grc and Rout.
  - ld (00000):
    - T3: Grb, BAout, Yin.
    - T4: Cout, ADD, Zin.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin.
    - T7: MDRout, Gra, Rin.
  - ldi (00001): T3 and T4 as ld, then T5: Zlowout, Gra, Rin.
  - st (00010):
    - T3–T5: as ld.
    - T6: Gra, Rout, MDRin.
    - T7: Write.
  - br (10010):
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, ADD, Zin.
    - T6: Zlowout and PCin, asserted only if CON=1.
  - jr (10011): T3: Gra, Rout, PCin.
  - nop (11001) and every other opcode: T3 asserts nothing and then returns to T0.
  - halt (11010): goes to S_HALT. In S_HALT all strobes are 0 and run=0. The block stays there until reset.
- Last execute step always returns to T0.

## Timing
- Memory states (T1 and ld T6 with Read; st T7 with Write) hold their strobes until mem_ready=1 is sampled on a rising edge, then advance.
- MDRin stays high throughout a read wait, so MDR holds the final data.
- With zero wait states:
  - fetch: 3 cycles.
  - R-type and I-type: 6 cycles total.
  - ld, st: 8.
  - ldi: 6.
  - br: 7.
  - jr: 4.
  - nop: 4.
- CON is sampled in T6, two edges after CONin.
- mem_ready outside a memory state is ignored.
- rst_n asserted in any state, including mid-wait or S_HALT, forces S_RST immediately and clears all strobes asynchronously.

## Configuration
- CU_MEM_WAIT_EN defined: memory states wait for mem_ready as above.
- CU_MEM_WAIT_EN undefined: each memory state lasts exactly one cycle and mem_ready is ignored. The port remains present.

## Structure
- Shared package cu_pkg holds:
  - state enumeration;
  - opcode constants;
  - alu_op encodings;
  - IR field positions (opcode 31:27, Ra 26:23, Rb 22:19, Rc 18:15, C 18:0).
- One sub-module, cu_decode, maps the opcode to an instruction class (RTYPE, ITYPE, LD, LDI, ST, BR, JR, NOP, HALT). The FSM branches on the class.

## Test plan
- Reset: rst_n low then released → all strobes 0 and run=1 during reset. First edge reaches T0 with PCout, MARin, IncPC and Zin all 1.
- add r1,r2,r3 (IR=0x18918000), mem_ready tied 1 → T3 Grb+Rout+Yin, T4 Grc+Rout+alu_op=0+Zin, T5 Zlowout+Gra+Rin, then T0 on cycle 7.
- ld with mem_ready low for 3 cycles in T6 → Read and MDRin high for 4 cycles, then T7 MDRout+Gra+Rin. Repeat without CU_MEM_WAIT_EN → Read high exactly 1 cycle.
- br with CON=0 and then with CON=1 → T6 PCin=0 in the first run and PCin=1 with Zlowout in the second; both return to T0.
- halt (opcode 11010) → run=0 and no strobes for 20 cycles. Asserting rst_n low → S_RST; release → T0.
- rst_n pulsed low during st T7 while Write is waiting → Write drops immediately (asynchronously), and fetch restarts from T0.

Source files
------------

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared states, opcodes, ALU codes and IR fields for control_unit
package cu_pkg;

  typedef enum logic [3:0] {
    S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE, C_ITYPE, C_LD, C_LDI, C_ST, C_BR, C_JR, C_NOP, C_HALT
  } iclass_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;
  localparam int C_HI   = 18;
  localparam int C_LO   = 0;

  // ALU operation used by the R-type / I-type T4 step
  function automatic logic [3:0] alu_for_op(input logic [4:0] op);
    case (op)
      OP_SUB:          alu_for_op = ALU_SUB;
      OP_AND, OP_ANDI: alu_for_op = ALU_AND;
      OP_OR,  OP_ORI:  alu_for_op = ALU_OR;
      default:         alu_for_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - maps an opcode to the instruction class the sequencer branches on
import cu_pkg::*;

module cu_decode (
  input  logic [4:0] opcode,
  output iclass_e    iclass
);

  // Unknown opcodes behave as nop
  always_comb begin
    iclass = C_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: iclass = C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:      iclass = C_ITYPE;
      OP_LD:                         iclass = C_LD;
      OP_LDI:                        iclass = C_LDI;
      OP_ST:                         iclass = C_ST;
      OP_BR:                         iclass = C_BR;
      OP_JR:                         iclass = C_JR;
      OP_HALT:                       iclass = C_HALT;
      default:                       iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore fetch/decode/execute sequencer; CU_MEM_WAIT_EN enables mem_ready waits
import cu_pkg::*;

module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        CONin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [3:0]  alu_op,
  output logic        run
);

  state_e     state, state_nx;
  iclass_e    iclass;
  logic [4:0] opcode;
  logic       mem_go;
  logic       ir_fields_unused;

  assign opcode = IR[OPC_HI:OPC_LO];
  // Register fields are consumed by the datapath's select/encode logic, not here
  assign ir_fields_unused = |IR[RA_HI:C_LO];

`ifdef CU_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_go = 1'b1;
  assign mem_ready_unused = mem_ready;
`endif

  cu_decode u_decode (
    .opcode (opcode),
    .iclass (iclass)
  );

  // State register; reset forces S_RST so every strobe drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_nx;
  end

  // Next state and Moore outputs from state, instruction class and CON
  always_comb begin
    state_nx = state;
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; CONin = 1'b0; IncPC = 1'b0;
    Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_op = ALU_ADD;
    run = 1'b1;
    case (state)
      S_RST: state_nx = T0;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_nx = T1;
      end
      T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (mem_go) state_nx = T2;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_nx = T3;
      end
      T3: begin
        case (iclass)
          C_RTYPE, C_ITYPE: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_nx = T4; end
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_nx = T4; end
          C_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_nx = T4; end
          C_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; state_nx = T0; end
          C_HALT: state_nx = S_HALT;
          default: state_nx = T0;
        endcase
      end
      T4: begin
        state_nx = T5;
        case (iclass)
          C_RTYPE: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_for_op(opcode); end
          C_ITYPE: begin Cout = 1'b1; Zin = 1'b1; alu_op = alu_for_op(opcode); end
          C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
          C_BR:    begin PCout = 1'b1; Yin = 1'b1; end
          default: state_nx = T0;
        endcase
      end
      T5: begin
        state_nx = T0;
        case (iclass)
          C_RTYPE, C_ITYPE, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; state_nx = T6; end
          C_BR:       begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; state_nx = T6; end
          default:    state_nx = T0;
        endcase
      end
      T6: begin
        state_nx = T0;
        case (iclass)
          C_LD: begin
            Read = 1'b1; MDRin = 1'b1;
            state_nx = mem_go ? T7 : T6;
          end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_nx = T7; end
          C_BR: begin Zlowout = CON; PCin = CON; end
          default: state_nx = T0;
        endcase
      end
      T7: begin
        state_nx = T0;
        case (iclass)
          C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST: begin
            Write = 1'b1;
            if (!mem_go) state_nx = T7;
          end
          default: state_nx = T0;
        endcase
      end
      S_HALT: run = 1'b0;
      default: state_nx = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR;
  logic        CON;
  logic        mem_ready;
  logic PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin, CONin, IncPC;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run;
  logic [3:0] alu_op;
  logic [19:0] strobes;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt;

  localparam logic [19:0] K_PCOUT   = 20'h80000;
  localparam logic [19:0] K_ZLOWOUT = 20'h40000;
  localparam logic [19:0] K_MDROUT  = 20'h20000;
  localparam logic [19:0] K_COUT    = 20'h10000;
  localparam logic [19:0] K_MARIN   = 20'h08000;
  localparam logic [19:0] K_PCIN    = 20'h04000;
  localparam logic [19:0] K_MDRIN   = 20'h02000;
  localparam logic [19:0] K_IRIN    = 20'h01000;
  localparam logic [19:0] K_YIN     = 20'h00800;
  localparam logic [19:0] K_ZIN     = 20'h00400;
  localparam logic [19:0] K_CONIN   = 20'h00200;
  localparam logic [19:0] K_INCPC   = 20'h00100;
  localparam logic [19:0] K_READ    = 20'h00080;
  localparam logic [19:0] K_WRITE   = 20'h00040;
  localparam logic [19:0] K_GRA     = 20'h00020;
  localparam logic [19:0] K_GRB     = 20'h00010;
  localparam logic [19:0] K_GRC     = 20'h00008;
  localparam logic [19:0] K_RIN     = 20'h00004;
  localparam logic [19:0] K_ROUT    = 20'h00002;
  localparam logic [19:0] K_BAOUT   = 20'h00001;
  localparam logic [19:0] K_NONE    = 20'h00000;

`ifdef CU_MEM_WAIT_EN
  localparam int LD_READ_CYCLES = 4;
`else
  localparam int LD_READ_CYCLES = 1;
`endif

  assign strobes = {PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin,
                    CONin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .IR(IR), .CON(CON), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .CONin(CONin), .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_op(alu_op), .run(run)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [19:0] s, input logic [3:0] alu,
                            input logic r);
    check(tag, {7'b0, run, alu_op, strobes}, {7'b0, r, alu, s});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir);
    expect_out("T0", K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 4'd0, 1'b1);
    IR = ir;
    step();
    expect_out("T1", K_ZLOWOUT | K_PCIN | K_READ | K_MDRIN, 4'd0, 1'b1);
    step();
    expect_out("T2", K_MDROUT | K_IRIN, 4'd0, 1'b1);
    step();
  endtask

  initial begin
    rst_n = 1'b0; IR = 32'h0; CON = 1'b0; mem_ready = 1'b1;
    #12;
    expect_out("reset", K_NONE, 4'd0, 1'b1);
    rst_n = 1'b1;
    step();

    // add r1,r2,r3
    fetch(32'h18918000);
    expect_out("add_T3", K_GRB | K_ROUT | K_YIN, 4'd0, 1'b1);
    step();
    expect_out("add_T4", K_GRC | K_ROUT | K_ZIN, 4'd0, 1'b1);
    step();
    expect_out("add_T5", K_ZLOWOUT | K_GRA | K_RIN, 4'd0, 1'b1);
    step();

    // sub: ALU code 1
    fetch(32'h20000000);
    step();
    expect_out("sub_T4", K_GRC | K_ROUT | K_ZIN, 4'd1, 1'b1);
    step(); step();

    // ori: constant operand, ALU code 3
    fetch(32'h68000000);
    expect_out("ori_T3", K_GRB | K_ROUT | K_YIN, 4'd0, 1'b1);
    step();
    expect_out("ori_T4", K_COUT | K_ZIN, 4'd3, 1'b1);
    step(); step();

    // ld with three not-ready edges in T6
    fetch(32'h00800000);
    expect_out("ld_T3", K_GRB | K_BAOUT | K_YIN, 4'd0, 1'b1);
    step();
    expect_out("ld_T4", K_COUT | K_ZIN, 4'd0, 1'b1);
    step();
    expect_out("ld_T5", K_ZLOWOUT | K_MARIN, 4'd0, 1'b1);
    step();
    expect_out("ld_T6", K_READ | K_MDRIN, 4'd0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (!Read) break;
      cnt++;
      mem_ready = (i >= 3);
      step();
    end
    mem_ready = 1'b1;
    check("ld_read_cycles", cnt, LD_READ_CYCLES);
    expect_out("ld_T7", K_MDROUT | K_GRA | K_RIN, 4'd0, 1'b1);
    step();

    // br, CON=0 then CON=1
    for (int c = 0; c < 2; c++) begin
      CON = c[0];
      fetch(32'h90000000);
      expect_out("br_T3", K_GRA | K_ROUT | K_CONIN, 4'd0, 1'b1);
      step();
      expect_out("br_T4", K_PCOUT | K_YIN, 4'd0, 1'b1);
      step();
      expect_out("br_T5", K_COUT | K_ZIN, 4'd0, 1'b1);
      step();
      if (c == 0) expect_out("br_T6_con0", K_NONE, 4'd0, 1'b1);
      else        expect_out("br_T6_con1", K_ZLOWOUT | K_PCIN, 4'd0, 1'b1);
      step();
    end
    CON = 1'b0;

    // jr then nop, each four cycles
    fetch(32'h98000000);
    expect_out("jr_T3", K_GRA | K_ROUT | K_PCIN, 4'd0, 1'b1);
    step();
    fetch(32'hC8000000);
    expect_out("nop_T3", K_NONE, 4'd0, 1'b1);
    step();

    // st, reset pulsed while Write is pending
    fetch(32'h10000000);
    step(); step();
    expect_out("st_T5", K_ZLOWOUT | K_MARIN, 4'd0, 1'b1);
    step();
    expect_out("st_T6", K_GRA | K_ROUT | K_MDRIN, 4'd0, 1'b1);
    mem_ready = 1'b0;
    step();
    expect_out("st_T7", K_WRITE, 4'd0, 1'b1);
`ifdef CU_MEM_WAIT_EN
    step();
    expect_out("st_T7_wait", K_WRITE, 4'd0, 1'b1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("st_async_reset", K_NONE, 4'd0, 1'b1);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();
    fetch(32'hC8000000);
    step();

    // halt, then recover by reset
    fetch(32'hD0000000);
    expect_out("halt_T3", K_NONE, 4'd0, 1'b1);
    step();
    for (int i = 0; i < 20; i++) begin
      expect_out("halted", K_NONE, 4'd0, 1'b0);
      step();
    end
    rst_n = 1'b0;
    #1;
    expect_out("halt_reset", K_NONE, 4'd0, 1'b1);
    rst_n = 1'b1;
    step();
    expect_out("after_halt_T0", K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 4'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
